// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The perf-counter width lives here so the top and the bench agree on it.
package pipe_seq_ctrl_pkg;

  // Width of the optional performance counters.
  localparam int PSC_PERF_W = 16;

  // Width of the watchdog counter; STALL_MAX is capped at 255.
  localparam int PSC_WD_W = 8;

  // Controller states.
  typedef enum logic [1:0] {
    PSC_RUN   = 2'd0,
    PSC_FLUSH = 2'd1,
    PSC_STALL = 2'd2,
    PSC_HALT  = 2'd3
  } psc_state_e;

  // Value loaded into the flush counter on an accepted jump.
  // The jump cycle itself is the first flush cycle, so the FLUSH state
  // has to cover the remaining FLUSH_CYCLES-1 cycles (counter runs down to 0).
  function automatic logic [3:0] psc_flush_init(input int flush_cycles);
    logic [3:0] v;
    v = 4'd0;
    if (flush_cycles > 1) v = 4'(flush_cycles - 2);
    return v;
  endfunction

endpackage

// File: rtl/pipe_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over enable;
// the count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller for the 3-stage core (pc/ifu -> idu -> exu).
// Arbitrates EXU jumps, EXU multi-cycle holds, IDU load-use hazards and
// debug halt; drives pc redirect, stage hold and a multi-cycle flush window,
// with a watchdog on consecutive stall cycles.
// Optional feature: define PIPE_SEQ_CTRL_PERF_EN to build the stall-cycle and
// accepted-jump performance counters; otherwise both outputs are tied to 0.
module pipe_seq_ctrl
  import pipe_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_MAX    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_en_i,
  input  logic [ADDR_W-1:0]     jump_to_addr_i,
  input  logic                  hold_req_i,
  input  logic                  hazard_i,
  input  logic                  halt_req_i,
  input  logic                  resume_i,
  output logic                  jump_en_o,
  output logic [ADDR_W-1:0]     jump_to_addr_o,
  output logic                  hold_flag_o,
  output logic                  flush_o,
  output logic                  halted_o,
  output logic                  stall_to_o,
  output logic [PSC_PERF_W-1:0] stall_cnt_o,
  output logic [PSC_PERF_W-1:0] flush_cnt_o
);

  localparam logic [3:0]          FLUSH_INIT  = psc_flush_init(FLUSH_CYCLES);
  // Watchdog fires in the stall cycle that would bring the count to STALL_MAX.
  localparam logic [PSC_WD_W-1:0] STALL_LAST  = PSC_WD_W'(STALL_MAX - 1);
  localparam bit                  MULTI_FLUSH = (FLUSH_CYCLES > 1);

  psc_state_e          state_q, state_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic                stall_to_q, stall_to_d;
  logic [PSC_WD_W-1:0] wd_cnt;
  logic                wd_en, wd_clr, wd_fire;
  logic                jump_acc, hold_c, flush_c;

  // Next state and per-cycle controls, in priority jump > hold > hazard > halt.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    jump_acc = 1'b0;
    hold_c   = 1'b0;
    flush_c  = 1'b0;
    wd_en    = 1'b0;
    wd_clr   = 1'b0;
    wd_fire  = 1'b0;
    case (state_q)
      PSC_RUN, PSC_STALL: begin
        if (jump_en_i) begin
          // Jump also abandons any stall in progress.
          jump_acc = 1'b1;
          flush_c  = 1'b1;
          wd_clr   = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = PSC_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            state_d = PSC_RUN;
          end
        end else if ((state_q == PSC_STALL) && !hold_req_i) begin
          // EXU released: stop holding this very cycle.
          wd_clr  = 1'b1;
          state_d = PSC_RUN;
        end else if (hold_req_i) begin
          if (wd_cnt == STALL_LAST) begin
            // Stall ran too long: let the pipe move and flag the error.
            wd_fire = 1'b1;
            wd_clr  = 1'b1;
            state_d = PSC_RUN;
          end else begin
            hold_c  = 1'b1;
            wd_en   = 1'b1;
            state_d = PSC_STALL;
          end
        end else if (hazard_i) begin
          hold_c = 1'b1;
        end else if (halt_req_i) begin
          state_d = PSC_HALT;
        end
      end
      PSC_FLUSH: begin
        flush_c = 1'b1;
        if (fcnt_q == 4'd0) state_d = PSC_RUN;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      PSC_HALT: begin
        hold_c = 1'b1;
        if (resume_i) state_d = PSC_RUN;
      end
      default: state_d = PSC_RUN;
    endcase
    stall_to_d = stall_to_q | wd_fire;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PSC_RUN;
      fcnt_q     <= 4'd0;
      stall_to_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      stall_to_q <= stall_to_d;
    end
  end

  // Consecutive stall-cycle counter for the watchdog.
  sat_counter #(.WIDTH(PSC_WD_W)) u_wd_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (wd_en),
    .clr_i (wd_clr),
    .q_o   (wd_cnt)
  );

  // Outputs are forced low while reset is held, including the pass-through address.
  assign jump_en_o      = !rst && jump_acc;
  assign jump_to_addr_o = jump_en_o ? jump_to_addr_i : '0;
  assign hold_flag_o    = !rst && hold_c;
  assign flush_o        = !rst && flush_c;
  assign halted_o       = !rst && (state_q == PSC_HALT);
  assign stall_to_o     = !rst && (stall_to_q || wd_fire);

`ifdef PIPE_SEQ_CTRL_PERF_EN
  // Cycles the pipe was held for a non-debug reason.
  sat_counter #(.WIDTH(PSC_PERF_W)) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .en_i  (hold_flag_o && (state_q != PSC_HALT)),
    .clr_i (1'b0),
    .q_o   (stall_cnt_o)
  );

  // Accepted jumps.
  sat_counter #(.WIDTH(PSC_PERF_W)) u_perf_flush (
    .clk   (clk),
    .rst   (rst),
    .en_i  (jump_en_o),
    .clr_i (1'b0),
    .q_o   (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_pipe_seq_ctrl;

  localparam int FC   = 2;
  localparam int SMAX = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jaddr = '0;
  logic        hold_req = 1'b0;
  logic        hazard = 1'b0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;

  logic        jump_en_o;
  logic [31:0] jump_to_addr_o;
  logic        hold_flag_o, flush_o, halted_o, stall_to_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int npass = 0;
  int nfail = 0;

  // Model state: remaining owed flush cycles, length of the current stall run,
  // halted flag, sticky watchdog error and perf tallies.
  int m_flush_left, m_stall_len, m_hold_cycles, m_jumps;
  bit m_halted, m_sticky;

  pipe_seq_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FC), .STALL_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en), .jump_to_addr_i(jaddr),
    .hold_req_i(hold_req), .hazard_i(hazard),
    .halt_req_i(halt_req), .resume_i(resume),
    .jump_en_o(jump_en_o), .jump_to_addr_o(jump_to_addr_o),
    .hold_flag_o(hold_flag_o), .flush_o(flush_o),
    .halted_o(halted_o), .stall_to_o(stall_to_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0; m_stall_len = 0; m_hold_cycles = 0; m_jumps = 0;
    m_halted = 0; m_sticky = 0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle against the model,
  // then advance the model to the next cycle.
  task automatic cyc(input logic j, input logic [31:0] a, input logic h,
                     input logic hz, input logic ht, input logic rs);
    logic        e_jmp, e_flush, e_hold, e_halted;
    logic [31:0] e_addr;
    int          e_scnt, e_fcnt;
    @(posedge clk); #1;
    jump_en = j; jaddr = a; hold_req = h; hazard = hz; halt_req = ht; resume = rs;
    @(negedge clk);
`ifdef PIPE_SEQ_CTRL_PERF_EN
    e_scnt = m_hold_cycles; e_fcnt = m_jumps;
`else
    e_scnt = 0; e_fcnt = 0;
`endif
    e_jmp = 0; e_flush = 0; e_hold = 0; e_halted = 0; e_addr = '0;
    if (m_halted) begin
      e_hold = 1; e_halted = 1;
      if (rs) m_halted = 0;
    end else if (m_flush_left > 0) begin
      e_flush = 1; m_flush_left--;
    end else if (j) begin
      e_jmp = 1; e_addr = a; e_flush = 1;
      m_flush_left = FC - 1; m_stall_len = 0; m_jumps++;
    end else if (m_stall_len > 0 && !h) begin
      m_stall_len = 0;
    end else if (h) begin
      if (m_stall_len + 1 == SMAX) begin
        m_sticky = 1; m_stall_len = 0;
      end else begin
        e_hold = 1; m_stall_len++;
      end
    end else if (hz) begin
      e_hold = 1;
    end else if (ht) begin
      m_halted = 1;
    end
    chk("jump_en",   32'(jump_en_o),   32'(e_jmp));
    chk("jump_addr", jump_to_addr_o,   e_addr);
    chk("flush",     32'(flush_o),     32'(e_flush));
    chk("hold_flag", 32'(hold_flag_o), 32'(e_hold));
    chk("halted",    32'(halted_o),    32'(e_halted));
    chk("stall_to",  32'(stall_to_o),  32'(m_sticky));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(e_scnt));
    chk("flush_cnt", 32'(flush_cnt_o), 32'(e_fcnt));
    if (e_hold && !e_halted && m_hold_cycles < 65535) m_hold_cycles++;
  endtask

  // Assert reset with random requests applied; outputs must drop at once.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    jump_en = 1'b1; jaddr = $urandom; hold_req = 1'b1; hazard = 1'b1;
    halt_req = 1'b1; resume = 1'($urandom);
    #1;
    chk("rst_jump_en",   32'(jump_en_o),   32'd0);
    chk("rst_jump_addr", jump_to_addr_o,   32'd0);
    chk("rst_flush",     32'(flush_o),     32'd0);
    chk("rst_hold",      32'(hold_flag_o), 32'd0);
    chk("rst_halted",    32'(halted_o),    32'd0);
    chk("rst_stall_to",  32'(stall_to_o),  32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
    @(posedge clk); #1;
    jump_en = 0; hold_req = 0; hazard = 0; halt_req = 0; resume = 0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    logic j, h, hz, ht, rs;
    model_reset();
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 10; i++) cyc(0, 32'h0, 0, 0, 0, 0);

    // Jump to 0x40; hazard during the second flush cycle is ignored.
    cyc(1, 32'h40, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 1, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);

    // Five-cycle EXU hold.
    for (int i = 0; i < 5; i++) cyc(0, 32'h0, 1, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);

    // Hold stuck high long enough for the watchdog to fire, then sticky.
    for (int i = 0; i < SMAX + 10; i++) cyc(0, 32'h0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 32'h0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 32'h0, 0, 0, 0, 0);

    // Jump beats hold in RUN, and a jump out of STALL.
    cyc(1, 32'h1234, 1, 1, 1, 0);
    cyc(0, 32'h0, 1, 0, 0, 0);
    cyc(0, 32'h0, 1, 0, 0, 0);
    cyc(0, 32'h0, 1, 0, 0, 0);
    cyc(1, 32'hCAFE0, 1, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);

    // Halt, then reset in the middle of HALT.
    cyc(0, 32'h0, 0, 0, 1, 0);
    cyc(1, 32'h80, 1, 1, 1, 0);
    cyc(0, 32'h0, 0, 0, 0, 0);
    do_reset();
    cyc(0, 32'h0, 0, 0, 0, 0);

    // Halt, then resume with halt still requested.
    cyc(0, 32'h0, 0, 0, 1, 0);
    cyc(0, 32'h0, 0, 1, 1, 0);
    cyc(0, 32'h0, 0, 0, 1, 1);
    cyc(0, 32'h0, 0, 0, 0, 0);
    cyc(0, 32'h0, 0, 1, 0, 0);

    // Randomized traffic with occasional resets.
    h = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        j  = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 4) == 0) h = ~h;
        hz = ($urandom_range(0, 7) == 0);
        ht = ($urandom_range(0, 24) == 0);
        rs = ($urandom_range(0, 3) == 0);
        cyc(j, $urandom, h, hz, ht, rs);
      end
    end

    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end

endmodule
